// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder front end (operand serializer)
// and back end (sum deserializer).
package serial_adder_pkg;

  localparam int SA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Width of a counter that must reach WIDTH-1.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_sum_deser.sv
// Receive-side deserializer: collects the LSB-first sum bits and final carry
// from the serial adder into one {carry, sum} word and offers it downstream
// over a valid/ready handshake.
module serial_sum_deser
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sum_bit,
  input  logic             cout,
  input  logic             sum_ready,
  output logic [WIDTH:0]   sum_word,
  output logic             sum_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  if (WIDTH < 2) begin : g_width_check
    $error("serial_sum_deser: WIDTH must be at least 2");
  end

  localparam int            CW       = cnt_w(WIDTH);
  localparam int            SRW      = WIDTH - 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   skip_q, skip_d;
  logic [SRW-1:0]  sr_q, sr_d;
  logic [SRW-1:0]  sr_first;
  logic [WIDTH:0]  word_q, word_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            start_ok;

  // A start is only meaningful once the bits of a dropped frame have passed.
  assign start_ok = start && (skip_q == '0);

  // Next-state logic: frame capture, restart on stray start, hold/handshake.
  // The shift register keeps only bits 0..WIDTH-2; the MSB and carry are
  // merged straight into the result word in the last bit cycle.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    skip_d    = skip_q;
    sr_d      = sr_q;
    word_d    = word_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;

    sr_first            = '0;
    sr_first[WIDTH-2]   = sum_bit;

    if (skip_q != '0) begin
      skip_d = skip_q - 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          sr_d      = sr_first;
          bit_cnt_d = CW'(1);
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (start_ok) begin
          // Partial frame is abandoned; this cycle's bit becomes bit 0.
          ferr_d    = 1'b1;
          sr_d      = sr_first;
          bit_cnt_d = CW'(1);
        end else if (bit_cnt_q == LAST_CNT) begin
          word_d    = {cout, sum_bit, sr_q};
          bit_cnt_d = '0;
          state_d   = HOLD;
        end else begin
          sr_d      = SRW'({sum_bit, sr_q} >> 1);
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      HOLD: begin
        if (sum_ready) begin
          if (start_ok) begin
            sr_d      = sr_first;
            bit_cnt_d = CW'(1);
            state_d   = SHIFT;
          end else begin
            state_d   = IDLE;
          end
        end else if (start_ok) begin
          // No room for the new frame: flag it and skip its remaining bits.
          ovr_d  = 1'b1;
          skip_d = LAST_CNT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, shift register, result word and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      skip_q    <= '0;
      sr_q      <= '0;
      word_q    <= '0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      skip_q    <= skip_d;
      sr_q      <= sr_d;
      word_q    <= word_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign sum_word  = word_q;
  assign sum_valid = (state_q == HOLD);
  assign busy      = (state_q == SHIFT);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_serial_sum_deser.sv
// Bench for serial_sum_deser: frames are built as the true sum of two
// operands, serialized LSB first, and the received word is compared with
// that arithmetic sum.
module tb_serial_sum_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sum_bit;
  logic         cout;
  logic         sum_ready;
  logic [W:0]   sum_word;
  logic         sum_valid;
  logic         busy;
  logic         frame_err;
  logic         overrun;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_sum_deser #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sum_bit   (sum_bit),
    .cout      (cout),
    .sum_ready (sum_ready),
    .sum_word  (sum_word),
    .sum_valid (sum_valid),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] add_ops(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Serialize bits lo..hi-1 of a {carry,sum} word; start accompanies bit 0.
  // cout carries noise except on the MSB cycle.
  task automatic drive_range(input logic [W:0] w, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      start   = (i == 0);
      sum_bit = w[i];
      cout    = (i == W-1) ? w[W] : 1'($urandom);
      tick();
    end
    start   = 1'b0;
    sum_bit = 1'b0;
    cout    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sum_bit = 1'b0; cout = 1'b0; sum_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    vectors++; if (sum_word !== '0) begin miscompares++; $display("FAIL reset_word: got %h want %h", sum_word, 9'h000); end
    vectors++; if (sum_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", sum_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got ferr=%b ovr=%b want 0 0", frame_err, overrun); end
    tick();
    vectors++; if (sum_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle: got valid=%b busy=%b want 0 0", sum_valid, busy); end
  endtask

  task automatic test_basic();
    logic [W:0] exp;
    exp = add_ops(8'h5A, 8'h3C);
    sum_ready = 1'b1;
    for (int i = 0; i < W; i++) begin
      start   = (i == 0);
      sum_bit = exp[i];
      cout    = (i == W-1) ? exp[W] : 1'($urandom);
      tick();
      if (i < W-1) begin
        vectors++;
        if (busy !== 1'b1 || sum_valid !== 1'b0) begin
          miscompares++; $display("FAIL basic_timing bit %0d: got busy=%b valid=%b want 1 0", i, busy, sum_valid);
        end
      end
    end
    start = 1'b0;
    vectors++; if (sum_valid !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL basic_valid: got valid=%b busy=%b want 1 0", sum_valid, busy); end
    vectors++; if (sum_word !== 9'h096) begin miscompares++; $display("FAIL basic_word: got %h want %h", sum_word, 9'h096); end
    tick();
    vectors++; if (sum_valid !== 1'b0) begin miscompares++; $display("FAIL basic_accept: got valid=%b want 0", sum_valid); end
  endtask

  task automatic test_carry();
    logic [W:0] exp;
    exp = add_ops(8'hFF, 8'h01);
    sum_ready = 1'b1;
    drive_range(exp, 0, W);
    vectors++; if (sum_valid !== 1'b1 || sum_word !== 9'h100) begin miscompares++; $display("FAIL carry_word: got valid=%b word=%h want 1 %h", sum_valid, sum_word, 9'h100); end
    tick();
    vectors++; if (sum_valid !== 1'b0) begin miscompares++; $display("FAIL carry_accept: got valid=%b want 0", sum_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W:0] x;
    logic [W:0] y;
    x = add_ops(W'($urandom), W'($urandom));
    y = add_ops(8'hA0, 8'h05);
    sum_ready = 1'b0;
    drive_range(x, 0, W);
    vectors++; if (sum_valid !== 1'b1 || sum_word !== x) begin miscompares++; $display("FAIL bp_first: got valid=%b word=%h want 1 %h", sum_valid, sum_word, x); end
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if (sum_valid !== 1'b1 || sum_word !== x || overrun !== 1'b0) begin
        miscompares++; $display("FAIL bp_hold cycle %0d: got valid=%b word=%h ovr=%b want 1 %h 0", c, sum_valid, sum_word, overrun, x);
      end
    end
    sum_ready = 1'b1;
    drive_range(y, 0, 1);
    vectors++; if (sum_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL b2b_turn: got valid=%b busy=%b want 0 1", sum_valid, busy); end
    drive_range(y, 1, W);
    vectors++; if (sum_valid !== 1'b1 || sum_word !== 9'h0A5) begin miscompares++; $display("FAIL b2b_second: got valid=%b word=%h want 1 %h", sum_valid, sum_word, 9'h0A5); end
    tick();
  endtask

  task automatic test_overrun();
    logic [W:0] x;
    logic [W:0] y;
    logic [W:0] z;
    bit         saw_valid;
    x = add_ops(8'h11, 8'h22);
    y = add_ops(8'hC3, 8'h7E);
    z = add_ops(W'($urandom), W'($urandom));
    sum_ready = 1'b0;
    drive_range(x, 0, W);
    drive_range(y, 0, W);
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    vectors++; if (sum_valid !== 1'b1 || sum_word !== x) begin miscompares++; $display("FAIL ovr_held: got valid=%b word=%h want 1 %h", sum_valid, sum_word, x); end
    sum_ready = 1'b1;
    tick();
    saw_valid = (sum_valid !== 1'b0) || (busy !== 1'b0);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (sum_valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
    end
    vectors++; if (saw_valid) begin miscompares++; $display("FAIL ovr_dropped: got dropped frame activity=1 want 0"); end
    drive_range(z, 0, W);
    vectors++; if (sum_valid !== 1'b1 || sum_word !== z || overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_next: got valid=%b word=%h ovr=%b want 1 %h 1", sum_valid, sum_word, overrun, z); end
    tick();
  endtask

  task automatic test_midframe_start();
    logic [W:0] g;
    logic [W:0] z;
    g = add_ops(W'($urandom), W'($urandom));
    z = add_ops(8'h4D, 8'h99);
    sum_ready = 1'b1;
    drive_range(g, 0, 4);
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL mid_pre: got ferr=%b want 0", frame_err); end
    drive_range(z, 0, W);
    vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("FAIL mid_ferr: got %b want 1", frame_err); end
    vectors++; if (sum_valid !== 1'b1 || sum_word !== z) begin miscompares++; $display("FAIL mid_word: got valid=%b word=%h want 1 %h", sum_valid, sum_word, z); end
    tick();
  endtask

  task automatic test_reset_midframe();
    logic [W:0] g;
    logic [W:0] z;
    g = add_ops(W'($urandom), W'($urandom));
    z = add_ops(W'($urandom), W'($urandom));
    sum_ready = 1'b1;
    drive_range(g, 0, 3);
    rst = 1'b1; sum_bit = g[3];
    tick();
    rst = 1'b0; sum_bit = 1'b0;
    vectors++;
    if (sum_word !== '0 || sum_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_clear: got word=%h valid=%b busy=%b ferr=%b ovr=%b want all 0", sum_word, sum_valid, busy, frame_err, overrun);
    end
    drive_range(z, 0, W);
    vectors++; if (sum_valid !== 1'b1 || sum_word !== z) begin miscompares++; $display("FAIL rstmid_frame: got valid=%b word=%h want 1 %h", sum_valid, sum_word, z); end
    tick();
  endtask

  task automatic test_random();
    logic [W:0] exp_q[$];
    logic [W:0] cur;
    logic [W:0] want;
    int         sent   = 0;
    int         got    = 0;
    int         bitidx = -1;
    const int   N      = 40;
    cur = '0;
    for (int cyc = 0; cyc < 3000 && got < N; cyc++) begin
      sum_ready = ($urandom_range(0, 3) != 0);
      start     = 1'b0;
      sum_bit   = 1'($urandom);
      cout      = 1'($urandom);
      if (bitidx < 0 && sent < N && (!sum_valid || sum_ready) && $urandom_range(0, 2) != 0) begin
        cur = add_ops(W'($urandom), W'($urandom));
        exp_q.push_back(cur);
        sent++;
        bitidx = 0;
      end
      if (bitidx >= 0) begin
        start   = (bitidx == 0);
        sum_bit = cur[bitidx];
        if (bitidx == W-1) cout = cur[W];
      end
      if (sum_valid && sum_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL rand_extra: got word=%h want no frame", sum_word);
        end else begin
          want = exp_q.pop_front();
          if (sum_word !== want) begin
            miscompares++; $display("FAIL rand_word #%0d: got %h want %h", got, sum_word, want);
          end
        end
        got++;
      end
      tick();
      if (bitidx >= 0) begin
        bitidx++;
        if (bitidx == W) bitidx = -1;
      end
    end
    start = 1'b0;
    vectors++; if (got != N) begin miscompares++; $display("FAIL rand_count: got %0d frames want %0d", got, N); end
    vectors++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin miscompares++; $display("FAIL rand_flags: got ferr=%b ovr=%b want 0 0", frame_err, overrun); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_overrun();
    test_reset();
    test_midframe_start();
    test_reset_midframe();
    test_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
